// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback path.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] regnum;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      WB_SRC_MEM = 1'b0,
      WB_SRC_ALU = 1'b1
   } wb_src_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order writeback queue. Exposes every slot in age order (index 0 = oldest)
// so the owner can run a newest-wins bypass search.
module regfile_wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_push,
   input  logic [ADDR_W-1:0]             i_push_reg,
   input  logic [DATA_W-1:0]             i_push_data,
   input  logic                          i_pop,
   output logic [$clog2(DEPTH):0]        o_occupancy,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [ADDR_W-1:0]             o_head_reg,
   output logic [DATA_W-1:0]             o_head_data,
   output logic [DEPTH-1:0]              o_age_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]  o_age_reg,
   output logic [DEPTH-1:0][DATA_W-1:0]  o_age_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [OCC_W-1:0] OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [ADDR_W-1:0] r_mem_reg  [DEPTH];
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [OCC_W-1:0]  r_occ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem_reg[k]  <= {ADDR_W{1'b0}};
            r_mem_data[k] <= {DATA_W{1'b0}};
         end
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_occ    <= {OCC_W{1'b0}};
      end else begin
         if (i_push) begin
            r_mem_reg[r_wr_ptr]  <= i_push_reg;
            r_mem_data[r_wr_ptr] <= i_push_data;
            r_wr_ptr             <= r_wr_ptr + PTR_ONE;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + OCC_ONE;
            2'b01:   r_occ <= r_occ - OCC_ONE;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_occupancy = r_occ;
   assign o_full      = (r_occ == OCC_FULL);
   assign o_empty     = (r_occ == {OCC_W{1'b0}});
   assign o_head_reg  = r_mem_reg[r_rd_ptr];
   assign o_head_data = r_mem_data[r_rd_ptr];

   for (genvar g = 0; g < DEPTH; g++) begin : g_age
      logic [PTR_W-1:0] w_slot;
      assign w_slot         = r_rd_ptr + PTR_W'(g);
      assign o_age_valid[g] = (OCC_W'(g) < r_occ);
      assign o_age_reg[g]   = r_mem_reg[w_slot];
      assign o_age_data[g]  = r_mem_data[w_slot];
   end

endmodule

// File: rtl/regfile_wb_unit.sv
// Write-side controller for the register file: arbitrates load/ALU writebacks
// into an in-order queue, drains one per cycle, and serves a 2-port bypass.
module regfile_wb_unit
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   input  logic [ADDR_W-1:0]      mem_reg,
   input  logic [DATA_W-1:0]      mem_data,
   input  logic                   alu_valid,
   output logic                   alu_ready,
   input  logic [ADDR_W-1:0]      alu_reg,
   input  logic [DATA_W-1:0]      alu_data,
   input  logic                   wb_en,
   output logic [ADDR_W-1:0]      Write_Reg_Num,
   output logic [DATA_W-1:0]      Write_Data,
   output logic                   RegWrite,
   input  logic [ADDR_W-1:0]      byp_reg_1,
   input  logic [ADDR_W-1:0]      byp_reg_2,
   output logic                   byp_hit_1,
   output logic                   byp_hit_2,
   output logic [DATA_W-1:0]      byp_data_1,
   output logic [DATA_W-1:0]      byp_data_2,
   output logic [$clog2(DEPTH):0] occupancy
);

   logic                         w_full;
   logic                         w_empty;
   logic                         w_mem_acc;
   logic                         w_alu_acc;
   wb_src_e                      w_src;
   logic [ADDR_W-1:0]            w_push_reg;
   logic [DATA_W-1:0]            w_push_data;
   logic                         w_push;
   logic                         w_pop;
   logic [ADDR_W-1:0]            w_head_reg;
   logic [DATA_W-1:0]            w_head_data;
   logic [DEPTH-1:0]             w_age_valid;
   logic [DEPTH-1:0][ADDR_W-1:0] w_age_reg;
   logic [DEPTH-1:0][DATA_W-1:0] w_age_data;

   // Ready looks only at stored occupancy; loads win over ALU results.
   assign mem_ready = !reset && !w_full;
   assign alu_ready = !reset && !w_full && !mem_valid;
   assign w_mem_acc = mem_valid && mem_ready;
   assign w_alu_acc = alu_valid && alu_ready;

   assign w_src       = w_mem_acc ? WB_SRC_MEM : WB_SRC_ALU;
   assign w_push_reg  = (w_src == WB_SRC_MEM) ? mem_reg  : alu_reg;
   assign w_push_data = (w_src == WB_SRC_MEM) ? mem_data : alu_data;
   assign w_push      = (w_mem_acc || w_alu_acc) && (w_push_reg != {ADDR_W{1'b0}});

   assign RegWrite      = !w_empty && wb_en;
   assign w_pop         = RegWrite;
   assign Write_Reg_Num = w_empty ? {ADDR_W{1'b0}} : w_head_reg;
   assign Write_Data    = w_empty ? {DATA_W{1'b0}} : w_head_data;

   regfile_wb_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_reg (w_push_reg),
      .i_push_data(w_push_data),
      .i_pop      (w_pop),
      .o_occupancy(occupancy),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_head_reg (w_head_reg),
      .o_head_data(w_head_data),
      .o_age_valid(w_age_valid),
      .o_age_reg  (w_age_reg),
      .o_age_data (w_age_data)
   );

   // Bypass search walks oldest to newest so the last match (newest) wins.
   always_comb begin
      byp_hit_1  = 1'b0;
      byp_data_1 = {DATA_W{1'b0}};
      byp_hit_2  = 1'b0;
      byp_data_2 = {DATA_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         if (w_age_valid[k] && (byp_reg_1 != {ADDR_W{1'b0}}) && (w_age_reg[k] == byp_reg_1)) begin
            byp_hit_1  = 1'b1;
            byp_data_1 = w_age_data[k];
         end else begin
            byp_hit_1  = byp_hit_1;
         end
         if (w_age_valid[k] && (byp_reg_2 != {ADDR_W{1'b0}}) && (w_age_reg[k] == byp_reg_2)) begin
            byp_hit_2  = 1'b1;
            byp_data_2 = w_age_data[k];
         end else begin
            byp_hit_2  = byp_hit_2;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Directed self-checking bench for regfile_wb_unit (DEPTH=4).
module tb_regfile_wb_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, mem_ready, alu_valid, alu_ready, wb_en, RegWrite;
   logic [4:0]  mem_reg, alu_reg, Write_Reg_Num, byp_reg_1, byp_reg_2;
   logic [31:0] mem_data, alu_data, Write_Data, byp_data_1, byp_data_2;
   logic        byp_hit_1, byp_hit_2;
   logic [2:0]  occupancy;

   int checks = 0;
   int errors = 0;

   logic [31:0] rf [32];
   logic [4:0]  log_reg [$];
   logic [31:0] log_data [$];

   always #5 clk = ~clk;

   regfile_wb_unit dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
      .wb_en(wb_en), .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data), .RegWrite(RegWrite),
      .byp_reg_1(byp_reg_1), .byp_reg_2(byp_reg_2), .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
      .byp_data_1(byp_data_1), .byp_data_2(byp_data_2), .occupancy(occupancy)
   );

   // Register-file model plus a log of every committed write.
   always @(posedge clk) begin
      if (RegWrite) begin
         rf[Write_Reg_Num] <= Write_Data;
         log_reg.push_back(Write_Reg_Num);
         log_data.push_back(Write_Data);
      end
   end

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0h exp 0", RegWrite); end
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got %0h exp 0", mem_ready); end
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got %0h exp 0", alu_ready); end
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
      checks++; if (byp_hit_1 !== 1'b0 || byp_data_1 !== 32'h0) begin errors++; $display("FAIL rst_byp got %0h/%0h exp 0/0", byp_hit_1, byp_data_1); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0h%0h exp 11", mem_ready, alu_ready); end
   endtask

   task automatic test_single_alu();
      wb_en = 1'b1;
      @(negedge clk);
      alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      checks++; if (alu_ready !== 1'b1 || RegWrite !== 1'b0) begin errors++; $display("FAIL t1_accept got rdy=%0h rw=%0h exp rdy=1 rw=0", alu_ready, RegWrite); end
      @(negedge clk);
      alu_valid = 1'b0;
      #1;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL t1_regwrite got %0h exp 1", RegWrite); end
      checks++; if (Write_Reg_Num !== 5'd5 || Write_Data !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_wdata got r%0d=%0h exp r5=deadbeef", Write_Reg_Num, Write_Data); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL t1_occ1 got %0d exp 1", occupancy); end
      @(negedge clk);
      checks++; if (occupancy !== 3'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL t1_drained got occ=%0d rw=%0h exp 0/0", occupancy, RegWrite); end
      checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_file_r5 got %0h exp deadbeef", rf[5]); end
   endtask

   task automatic test_arbitration();
      log_reg.delete(); log_data.delete();
      @(negedge clk);
      mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h11;
      alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h22;
      #1;
      checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL t2_prio got mem=%0h alu=%0h exp 1/0", mem_ready, alu_ready); end
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      checks++; if (alu_ready !== 1'b1 || Write_Reg_Num !== 5'd3) begin errors++; $display("FAIL t2_second got rdy=%0h head=r%0d exp 1/r3", alu_ready, Write_Reg_Num); end
      @(negedge clk);
      alu_valid = 1'b0;
      #1;
      checks++; if (occupancy !== 3'd1 || Write_Reg_Num !== 5'd4 || Write_Data !== 32'h22) begin errors++; $display("FAIL t2_pushpop got occ=%0d r%0d=%0h exp 1 r4=22", occupancy, Write_Reg_Num, Write_Data); end
      repeat (2) @(negedge clk);
      checks++; if (log_reg.size() !== 2) begin errors++; $display("FAIL t2_count got %0d exp 2", log_reg.size()); end
      else begin
         checks++; if (log_reg[0] !== 5'd3 || log_data[0] !== 32'h11 || log_reg[1] !== 5'd4 || log_data[1] !== 32'h22)
            begin errors++; $display("FAIL t2_order got r%0d=%0h,r%0d=%0h exp r3=11,r4=22", log_reg[0], log_data[0], log_reg[1], log_data[1]); end
      end
   endtask

   task automatic test_full();
      log_reg.delete(); log_data.delete();
      wb_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         alu_valid = 1'b1; alu_reg = 5'(10 + i); alu_data = 32'h100 + 32'(i);
         #1;
         checks++; if (alu_ready !== (i < 4)) begin errors++; $display("FAIL t3_ready%0d got %0h exp %0h", i, alu_ready, (i < 4)); end
      end
      checks++; if (occupancy !== 3'd4 || RegWrite !== 1'b0) begin errors++; $display("FAIL t3_full got occ=%0d rw=%0h exp 4/0", occupancy, RegWrite); end
      @(negedge clk);
      alu_valid = 1'b0; wb_en = 1'b1;
      #1;
      checks++; if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd10 || mem_ready !== 1'b0) begin errors++; $display("FAIL t3_pop1 got rw=%0h r%0d mrdy=%0h exp 1 r10 0", RegWrite, Write_Reg_Num, mem_ready); end
      @(negedge clk);
      checks++; if (occupancy !== 3'd3 || mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL t3_reopen got occ=%0d rdy=%0h%0h exp 3 11", occupancy, mem_ready, alu_ready); end
      repeat (3) @(negedge clk);
      checks++; if (occupancy !== 3'd0 || log_reg.size() !== 4) begin errors++; $display("FAIL t3_drain got occ=%0d n=%0d exp 0/4", occupancy, log_reg.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (log_reg[i] !== 5'(10 + i) || log_data[i] !== 32'h100 + 32'(i))
               begin errors++; $display("FAIL t3_order%0d got r%0d=%0h exp r%0d=%0h", i, log_reg[i], log_data[i], 10 + i, 32'h100 + 32'(i)); end
         end
      end
   endtask

   task automatic test_bypass();
      wb_en = 1'b0;
      @(negedge clk);
      alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hA;
      @(negedge clk);
      alu_data = 32'hB;
      @(negedge clk);
      alu_valid = 1'b0; byp_reg_1 = 5'd7; byp_reg_2 = 5'd8;
      #1;
      checks++; if (byp_hit_1 !== 1'b1 || byp_data_1 !== 32'hB) begin errors++; $display("FAIL t4_newest got %0h/%0h exp 1/b", byp_hit_1, byp_data_1); end
      checks++; if (byp_hit_2 !== 1'b0 || byp_data_2 !== 32'h0) begin errors++; $display("FAIL t4_miss got %0h/%0h exp 0/0", byp_hit_2, byp_data_2); end
      wb_en = 1'b1;
      @(negedge clk);
      checks++; if (RegWrite !== 1'b1 || byp_hit_1 !== 1'b1 || byp_data_1 !== 32'hB) begin errors++; $display("FAIL t4_head_hit got rw=%0h %0h/%0h exp 1 1/b", RegWrite, byp_hit_1, byp_data_1); end
      @(negedge clk);
      checks++; if (byp_hit_1 !== 1'b0 || byp_data_1 !== 32'h0) begin errors++; $display("FAIL t4_empty got %0h/%0h exp 0/0", byp_hit_1, byp_data_1); end
   endtask

   task automatic test_r0();
      log_reg.delete(); log_data.delete();
      wb_en = 1'b1;
      @(negedge clk);
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL t5_ready got %0h exp 1", alu_ready); end
      @(negedge clk);
      alu_valid = 1'b0;
      #1;
      checks++; if (occupancy !== 3'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL t5_filtered got occ=%0d rw=%0h exp 0/0", occupancy, RegWrite); end
      repeat (2) @(negedge clk);
      checks++; if (log_reg.size() !== 0) begin errors++; $display("FAIL t5_nowrite got %0d exp 0", log_reg.size()); end
   endtask

   task automatic test_reset_mid();
      wb_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         alu_valid = 1'b1; alu_reg = 5'(20 + i); alu_data = 32'h200 + 32'(i);
      end
      @(negedge clk);
      alu_valid = 1'b0; wb_en = 1'b1;
      log_reg.delete(); log_data.delete();
      #1;
      checks++; if (RegWrite !== 1'b1 || Write_Reg_Num !== 5'd20 || occupancy !== 3'd3) begin errors++; $display("FAIL t6_pre got rw=%0h r%0d occ=%0d exp 1 r20 3", RegWrite, Write_Reg_Num, occupancy); end
      #1 reset = 1'b1;
      #1;
      checks++; if (RegWrite !== 1'b0 || Write_Reg_Num !== 5'd0 || Write_Data !== 32'h0) begin errors++; $display("FAIL t6_async got rw=%0h r%0d=%0h exp 0 r0=0", RegWrite, Write_Reg_Num, Write_Data); end
      checks++; if (occupancy !== 3'd0 || mem_ready !== 1'b0) begin errors++; $display("FAIL t6_cleared got occ=%0d mrdy=%0h exp 0/0", occupancy, mem_ready); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1 || occupancy !== 3'd0) begin errors++; $display("FAIL t6_release got rdy=%0h%0h occ=%0d exp 11 0", mem_ready, alu_ready, occupancy); end
      repeat (3) @(negedge clk);
      checks++; if (log_reg.size() !== 0) begin errors++; $display("FAIL t6_stale got %0d writes exp 0", log_reg.size()); end
   endtask

   initial begin
      reset = 1'b1;
      mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'h0;
      alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'h0;
      wb_en = 1'b0; byp_reg_1 = 5'd5; byp_reg_2 = 5'd0;
      test_reset();
      test_single_alu();
      test_arbitration();
      test_full();
      test_bypass();
      test_r0();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
